// File: rtl/rf_write_arbiter_pkg.sv
// Shared constants and FSM state type for the register-file write-port arbiter.
package rf_write_arbiter_pkg;
  localparam int unsigned NREQ_C = 16;
  localparam int unsigned IDX_W  = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;
endpackage

// File: rtl/rf_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after start, wrapping.
module rr_pick
  import rf_write_arbiter_pkg::*;
(
  input  logic [NREQ_C-1:0] req,
  input  logic [IDX_W-1:0]  start,
  output logic              hit,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int unsigned k = 0; k < NREQ_C; k++) begin
      // Index arithmetic wraps naturally in IDX_W bits.
      pos = start + IDX_W'(k);
      if (!hit && req[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin write-port arbiter with registered one-hot grant and per-grant timeout.
module rf_write_arbiter
  import rf_write_arbiter_pkg::*;
#(
  parameter int unsigned NREQ    = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req,
  input  logic              done,
  output logic [NREQ-1:0]   grant,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              grant_valid,
  output logic              timeout_err
);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic              valid_q, valid_d;
  logic              tmo_q, tmo_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rdy_q;

  logic              pick_hit;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  pick_start;
  logic              tmo_hit;

  assign pick_start = last_q + IDX_W'(1);
  assign tmo_hit    = (TIMEOUT != 0) && (cnt_q == 8'(TIMEOUT - 1));

  rr_pick u_pick (
    .req   (req),
    .start (pick_start),
    .hit   (pick_hit),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // rdy_q holds off arbitration for one edge after reset release.
        if (rdy_q && pick_hit) begin
          state_d           = ST_BUSY;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          idx_d             = pick_idx;
          valid_d           = 1'b1;
          cnt_d             = '0;
        end
      end
      ST_BUSY: begin
        if (done || !req[idx_q] || tmo_hit) begin
          // A normal release takes precedence over a coincident timeout.
          tmo_d   = !(done || !req[idx_q]);
          state_d = ST_IDLE;
          grant_d = '0;
          idx_d   = '0;
          valid_d = 1'b0;
          last_d  = idx_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      tmo_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      tmo_q   <= tmo_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      rdy_q   <= 1'b1;
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = idx_q;
  assign grant_valid = valid_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized bench for rf_write_arbiter against a behavioural model.
module tb_rf_write_arbiter;

  localparam int TMO = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
  logic        timeout_err;

  int passed;
  int total;

  // Behavioural model state
  int m_busy, m_owner, m_last, m_cnt, m_tmo, m_rdy;

  rf_write_arbiter #(.NREQ(16), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int winner(input logic [15:0] r, input int last);
    for (int k = 1; k <= 16; k++) begin
      int p;
      p = (last + k) % 16;
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = 15; m_cnt = 0; m_tmo = 0; m_rdy = 0;
  endtask

  task automatic model_edge();
    int was_rdy;
    was_rdy = m_rdy;
    m_tmo = 0;
    if (m_busy != 0) begin
      if (done || !req[m_owner]) begin
        m_busy = 0; m_last = m_owner;
      end else if (TMO != 0 && m_cnt == TMO - 1) begin
        m_busy = 0; m_last = m_owner; m_tmo = 1;
      end else begin
        m_cnt++;
      end
    end else if (was_rdy != 0 && req != 16'h0) begin
      m_owner = winner(req, m_last);
      m_busy = 1;
      m_cnt = 0;
    end
    m_rdy = 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    logic [15:0] eg;
    eg = (m_busy != 0) ? (16'h1 << m_owner) : 16'h0;
    chk({tag, ".grant"}, 32'(grant), 32'(eg));
    chk({tag, ".idx"}, 32'(grant_idx), (m_busy != 0) ? 32'(m_owner) : 32'h0);
    chk({tag, ".valid"}, 32'(grant_valid), 32'(m_busy));
    chk({tag, ".tmo"}, 32'(timeout_err), 32'(m_tmo));
    chk({tag, ".onehot"}, 32'($countones(grant) <= 1), 32'h1);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n = 1'b0; req = 16'h0; done = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst.grant", 32'(grant), 32'h0);
    chk("rst.valid", 32'(grant_valid), 32'h0);

    // Reset release and first grant latency
    rst_n = 1'b1; req = 16'h0001;
    step("sync1");
    chk("sync1.nogrant", 32'(grant), 32'h0);
    step("first");
    chk("first.grant", 32'(grant), 32'h0001);
    chk("first.idx", 32'(grant_idx), 32'h0);
    done = 1'b1;
    step("rel0");
    chk("rel0.grant", 32'(grant), 32'h0);
    done = 1'b0; req = 16'h0;
    step("idle0");
    step("idle1");

    // All requesting, done held: rotation with IDLE gaps
    req = 16'hFFFF; done = 1'b1;
    for (int i = 0; i < 34; i++) step("rot");
    req = 16'h0;
    step("drain0");
    step("drain1");
    done = 1'b0;

    // Wrap past the last owner
    req = 16'h0008;
    step("w3");
    chk("w3.idx", 32'(grant_idx), 32'h3);
    done = 1'b1;
    step("w3rel");
    done = 1'b0; req = 16'h0009;
    step("wrap");
    chk("wrap.idx", 32'(grant_idx), 32'h0);
    done = 1'b1; req = 16'h0;
    step("wraprel");
    done = 1'b0;
    step("wrapidle");

    // Timeout revocation
    req = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      step("tmo_hold");
      chk("tmo_hold.grant", 32'(grant), 32'h0020);
    end
    step("tmo_fire");
    chk("tmo_fire.err", 32'(timeout_err), 32'h1);
    chk("tmo_fire.grant", 32'(grant), 32'h0);
    req = 16'h0021;
    step("tmo_next");
    chk("tmo_next.idx", 32'(grant_idx), 32'h0);
    chk("tmo_next.err", 32'(timeout_err), 32'h0);
    done = 1'b1; req = 16'h0;
    step("tmo_rel");
    done = 1'b0;
    step("tmo_idle");

    // done coincident with timeout is a normal release
    req = 16'h0040;
    for (int i = 0; i < 4; i++) step("dt_hold");
    done = 1'b1;
    step("dt_rel");
    chk("dt_rel.grant", 32'(grant), 32'h0);
    chk("dt_rel.err", 32'(timeout_err), 32'h0);
    done = 1'b0; req = 16'h0;
    step("dt_idle");

    // Grant held under req changes; release by dropping own req
    req = 16'h0080;
    step("g7");
    chk("g7.idx", 32'(grant_idx), 32'h7);
    req = 16'h0180;
    step("g7hold");
    chk("g7hold.grant", 32'(grant), 32'h0080);
    req = 16'h0101;
    step("g7drop");
    chk("g7drop.grant", 32'(grant), 32'h0);
    chk("g7drop.err", 32'(timeout_err), 32'h0);
    step("g8");
    chk("g8.idx", 32'(grant_idx), 32'h8);
    done = 1'b1; req = 16'h0;
    step("g8rel");
    done = 1'b0;
    step("g8idle");

    // Asynchronous reset mid-BUSY
    req = 16'h0004;
    step("ar_busy");
    chk("ar_busy.idx", 32'(grant_idx), 32'h2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("ar.grant", 32'(grant), 32'h0);
    chk("ar.valid", 32'(grant_valid), 32'h0);
    chk("ar.err", 32'(timeout_err), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; req = 16'h8001;
    step("ar_sync");
    chk("ar_sync.grant", 32'(grant), 32'h0);
    step("ar_first");
    chk("ar_first.idx", 32'(grant_idx), 32'h0);
    chk("ar_first.valid", 32'(grant_valid), 32'h1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 16'($urandom) & 16'($urandom);
      done = ($urandom_range(0, 4) == 0);
      step("rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
